fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of prefetch queue entries (power of two, 2..16).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 MEM_REQ  output  1  instruction memory read request.
REQ-006 MEM_ADDR  output  32  word-aligned read address, valid while MEM_REQ is high.
REQ-007 MEM_ACK  input  1  memory completes the request this cycle.
REQ-008 MEM_RDATA  input  32  instruction word, valid when MEM_ACK is high.
REQ-009 INST_VALID  output  1  queue head holds an instruction for the core.
REQ-010 INST_DATA  output  32  queue head instruction word.
REQ-011 INST_PC  output  32  address of the INST_DATA word.
REQ-012 INST_READY  input  1  core consumes the head when INST_VALID is also high.
REQ-013 REDIRECT  input  1  branch/jump taken; flush and refetch.
REQ-014 REDIRECT_PC  input  32  new fetch address; bits [1:0] SHALL be treated as zero.

Function
REQ-015 The block SHALL hold a fetch PC register, initialised to RESET_PC, incremented by 4 (mod 2^32) on each accepted non-discarded MEM_ACK.
REQ-016 The block SHALL implement states IDLE, REQ, DISCARD.
REQ-017 IDLE -> REQ when queue count plus outstanding requests < DEPTH and REDIRECT is low; MEM_REQ SHALL be high with MEM_ADDR = fetch PC in REQ only.
REQ-018 In REQ, MEM_REQ and MEM_ADDR SHALL stay stable until MEM_ACK; on MEM_ACK the block SHALL push {fetch PC, MEM_RDATA} and go to REQ again if space remains after the push, else IDLE.
REQ-019 At most one memory request SHALL be outstanding.
REQ-020 A pushed entry SHALL appear at the queue head, when the queue was empty, with INST_VALID high in the cycle after MEM_ACK.
REQ-021 Pop occurs when INST_VALID and INST_READY are high; simultaneous push and pop SHALL leave the count unchanged and keep order.
REQ-022 INST_VALID SHALL be low when the queue is empty; INST_DATA/INST_PC SHALL be don't-care then.
REQ-023 On REDIRECT: queue cleared, fetch PC <= REDIRECT_PC with bits [1:0] cleared, INST_VALID low the next cycle; REDIRECT has priority over push and pop.
REQ-024 REDIRECT in REQ without MEM_ACK SHALL move to DISCARD, holding MEM_REQ and the old MEM_ADDR until MEM_ACK; that data SHALL be dropped, then the block goes to REQ with the new PC.
REQ-025 REDIRECT in the same cycle as MEM_ACK SHALL drop the returned word and go to REQ with the new PC next cycle.
REQ-026 REDIRECT in DISCARD SHALL update fetch PC only and remain in DISCARD.
REQ-027 REDIRECT in IDLE SHALL go to REQ with MEM_ADDR = new PC in the next cycle.

Reset
REQ-028 While RST is high: state IDLE, fetch PC = RESET_PC, queue empty, MEM_REQ = 0, INST_VALID = 0, MEM_ADDR = RESET_PC.
REQ-029 RST asserted mid-request SHALL abandon the request without waiting for MEM_ACK; the first request after release SHALL occur in the first cycle after RST falls.

Configuration
REQ-030 With macro FETCH_PERF_CNT_EN defined, the block SHALL add output PERF_FETCHED[31:0], counting pops (wrapping at 2^32, reset 0).
REQ-031 Without FETCH_PERF_CNT_EN, PERF_FETCHED and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-032 Reset release, MEM_ACK every request, INST_READY=1 -> INST_PC sequence 0,4,8,12 with matching MEM_RDATA words, one instruction per cycle after warm-up.
REQ-033 INST_READY=0, MEM_ACK always 1 -> exactly DEPTH (4) requests issued, then MEM_REQ low; one pop -> one new request.
REQ-034 REDIRECT with REDIRECT_PC=32'h0000_0103 while MEM_REQ pending, MEM_ACK three cycles later -> old data dropped, next MEM_ADDR=32'h0000_0100, first INST_PC=32'h0000_0100.
REQ-035 REDIRECT and MEM_ACK in the same cycle, REDIRECT_PC=32'h40 -> no push, INST_VALID low next cycle, next MEM_ADDR=32'h40.
REQ-036 RST pulse while MEM_REQ high and queue holding 3 entries -> INST_VALID=0, MEM_REQ=0 during reset, MEM_ADDR=RESET_PC after release.
REQ-037 With FETCH_PERF_CNT_EN, 10 pops, then REDIRECT -> PERF_FETCHED=10, unchanged by flush.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction prefetcher: one outstanding read, DEPTH-entry {pc,word} queue, redirect flush; FETCH_PERF_CNT_EN adds PERF_FETCHED.
// Latency: a word acked in cycle N is at the head in N+1; INST_READY low stops fetching once queue+outstanding fills.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST_DATA,
  output logic [31:0] INST_PC,
  input  logic        INST_READY,
  input  logic        REDIRECT,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] PERF_FETCHED,
`endif
  input  logic [31:0] REDIRECT_PC
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_old_addr;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_cnt_after;
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic          w_push, w_pop, w_mem_req;
  logic [31:0]   w_redir_pc;

  assign w_redir_pc = REDIRECT_PC & 32'hFFFF_FFFC;
  assign INST_VALID = (r_count != '0);
  assign INST_PC    = r_q_pc[r_rd_ptr];
  assign INST_DATA  = r_q_data[r_rd_ptr];
  assign w_pop      = INST_VALID & INST_READY & ~REDIRECT;
  assign w_push     = (r_state == S_REQ) & MEM_ACK & ~REDIRECT;
  assign w_cnt_after = r_count + CW'(1) - {{(CW-1){1'b0}}, w_pop};
  assign MEM_REQ    = w_mem_req;
  // While discarding, the bus must still see the abandoned request's address.
  assign MEM_ADDR   = (r_state == S_DISCARD) ? r_old_addr : r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REDIRECT || (r_count < DEPTH_C)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_mem_req = 1'b1;
        if (REDIRECT) w_state_nxt = MEM_ACK ? S_REQ : S_DISCARD;
        else if (MEM_ACK) w_state_nxt = (w_cnt_after < DEPTH_C) ? S_REQ : S_IDLE;
      end
      S_DISCARD: begin
        w_mem_req = 1'b1;
        if (MEM_ACK) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_old_addr <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_REQ && REDIRECT && !MEM_ACK) r_old_addr <= r_pc;
      if (REDIRECT) begin
        r_pc     <= w_redir_pc;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_pc     <= r_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_data[r_wr_ptr] <= MEM_RDATA;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf;
  assign PERF_FETCHED = r_perf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_perf <= '0;
    else if (w_pop) r_perf <= r_perf + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a queue-level model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        CLK, RST, MEM_REQ, MEM_ACK, INST_VALID, INST_READY, REDIRECT;
  logic [31:0] MEM_ADDR, MEM_RDATA, INST_DATA, INST_PC, REDIRECT_PC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] PERF_FETCHED;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .INST_VALID(INST_VALID), .INST_DATA(INST_DATA), .INST_PC(INST_PC),
    .INST_READY(INST_READY), .REDIRECT(REDIRECT),
`ifdef FETCH_PERF_CNT_EN
    .PERF_FETCHED(PERF_FETCHED),
`endif
    .REDIRECT_PC(REDIRECT_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
    MEM_ACK = ack; INST_READY = rdy; REDIRECT = redir; REDIRECT_PC = rpc;
    MEM_RDATA = memf(MEM_ADDR);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    MEM_ACK = 0; INST_READY = 0; REDIRECT = 0; REDIRECT_PC = 0; MEM_RDATA = 0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (MEM_REQ !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", MEM_REQ); end
    n_checks++; if (INST_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", INST_VALID); end
    n_checks++; if (MEM_ADDR !== RST_PC) begin n_errors++; $display("FAIL reset_addr: got %h expected %h", MEM_ADDR, RST_PC); end
    do_reset();
    tick(0, 0, 0, 0);
    n_checks++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== RST_PC) begin
      n_errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", MEM_REQ, MEM_ADDR, RST_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    logic [31:0] dats[$];
    int nvalid = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (INST_VALID) begin nvalid++; pcs.push_back(INST_PC); dats.push_back(INST_DATA); end
      tick(MEM_REQ, 1, 0, 0);
    end
    n_checks++; if (nvalid != 8) begin n_errors++; $display("FAIL stream_rate: got %0d valid cycles expected 8", nvalid); end
    for (int i = 0; i < pcs.size(); i++) begin
      n_checks++;
      if (pcs[i] !== RST_PC + 32'(4 * i) || dats[i] !== memf(RST_PC + 32'(4 * i))) begin
        n_errors++; $display("FAIL stream_pc%0d: got pc=%h data=%h expected pc=%h data=%h", i, pcs[i], dats[i],
                             RST_PC + 32'(4 * i), memf(RST_PC + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_full();
    int acks = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (MEM_REQ) acks++;
      tick(MEM_REQ, 0, 0, 0);
    end
    n_checks++; if (acks != DEPTH) begin n_errors++; $display("FAIL full_acks: got %0d expected %0d", acks, DEPTH); end
    n_checks++; if (MEM_REQ !== 1'b0 || INST_VALID !== 1'b1) begin
      n_errors++; $display("FAIL full_idle: got req=%b valid=%b expected req=0 valid=1", MEM_REQ, INST_VALID); end
    tick(0, 1, 0, 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (MEM_REQ) acks++;
      tick(MEM_REQ, 0, 0, 0);
    end
    n_checks++; if (acks != 1 || MEM_REQ !== 1'b0) begin
      n_errors++; $display("FAIL refill: got acks=%0d req=%b expected acks=1 req=0", acks, MEM_REQ); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h0000_0103);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== RST_PC || INST_VALID !== 1'b0) begin
        n_errors++; $display("FAIL discard_hold%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                             i, MEM_REQ, MEM_ADDR, INST_VALID, RST_PC); end
      tick(i == 1, 1, 0, 0);
    end
    n_checks++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h0000_0100 || INST_VALID !== 1'b0) begin
      n_errors++; $display("FAIL discard_next: got req=%b addr=%h valid=%b expected req=1 addr=00000100 valid=0",
                           MEM_REQ, MEM_ADDR, INST_VALID); end
    tick(1, 1, 0, 0);
    n_checks++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h0000_0100 || INST_DATA !== memf(32'h100)) begin
      n_errors++; $display("FAIL discard_first: got valid=%b pc=%h data=%h expected valid=1 pc=00000100 data=%h",
                           INST_VALID, INST_PC, INST_DATA, memf(32'h100)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h0000_0040);
    n_checks++; if (INST_VALID !== 1'b0 || MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h40) begin
      n_errors++; $display("FAIL redir_ack: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000040",
                           INST_VALID, MEM_REQ, MEM_ADDR); end
    tick(1, 0, 0, 0);
    n_checks++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h40 || INST_DATA !== memf(32'h40)) begin
      n_errors++; $display("FAIL redir_ack_head: got valid=%b pc=%h expected valid=1 pc=00000040", INST_VALID, INST_PC); end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    do_reset();
    for (int i = 0; i < 20 && acks < 3; i++) begin
      if (MEM_REQ) acks++;
      tick(MEM_REQ, 0, 0, 0);
    end
    n_checks++; if (acks != 3 || MEM_REQ !== 1'b1 || INST_VALID !== 1'b1) begin
      n_errors++; $display("FAIL midrst_setup: got acks=%0d req=%b valid=%b expected 3/1/1", acks, MEM_REQ, INST_VALID); end
    RST = 1'b1;
    #1;
    n_checks++; if (MEM_REQ !== 1'b0 || INST_VALID !== 1'b0) begin
      n_errors++; $display("FAIL midrst_during: got req=%b valid=%b expected 0/0", MEM_REQ, INST_VALID); end
    @(negedge CLK);
    RST = 1'b0;
    n_checks++; if (MEM_ADDR !== RST_PC || INST_VALID !== 1'b0) begin
      n_errors++; $display("FAIL midrst_release: got addr=%h valid=%b expected addr=%h valid=0", MEM_ADDR, INST_VALID, RST_PC); end
    tick(0, 0, 0, 0);
    n_checks++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== RST_PC) begin
      n_errors++; $display("FAIL midrst_first_req: got req=%b addr=%h expected req=1 addr=%h", MEM_REQ, MEM_ADDR, RST_PC); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    int pops = 0;
    do_reset();
    n_checks++; if (PERF_FETCHED !== 32'd0) begin n_errors++; $display("FAIL perf_reset: got %0d expected 0", PERF_FETCHED); end
    for (int i = 0; i < 40 && pops < 10; i++) begin
      if (INST_VALID) pops++;
      tick(MEM_REQ, 1, 0, 0);
    end
    tick(0, 0, 1, 32'h200);
    n_checks++; if (pops != 10 || PERF_FETCHED !== 32'd10) begin
      n_errors++; $display("FAIL perf_count: got %0d (pops %0d) expected 10", PERF_FETCHED, pops); end
    tick(0, 0, 0, 0);
    n_checks++; if (PERF_FETCHED !== 32'd10) begin n_errors++; $display("FAIL perf_flush: got %0d expected 10", PERF_FETCHED); end
  endtask
`endif

  // Model: occupancy, next fetch address and next expected pop address; a request is
  // tainted when a redirect lands while it is outstanding, and its ack is then dropped.
  task automatic test_random();
    logic [31:0] exp_fetch, exp_pop, addr, prev_addr, rpc;
    logic v, req, ack, rdy, redir, tainted, prev_req, prev_ack;
    int occ;
    do_reset();
    exp_fetch = RST_PC; exp_pop = RST_PC; occ = 0; tainted = 0;
    prev_req = 0; prev_ack = 0; prev_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = INST_VALID; req = MEM_REQ; addr = MEM_ADDR;
      n_checks++; if (v !== (occ > 0)) begin
        n_errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", cyc, v, occ > 0); end
      if (occ == DEPTH) begin
        n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL rnd_overfetch @%0d: got req=%b expected 0", cyc, req); end
      end
      if (prev_req && !prev_ack) begin
        n_checks++; if (req !== 1'b1 || addr !== prev_addr) begin
          n_errors++; $display("FAIL rnd_stable @%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, req, addr, prev_addr); end
      end
      ack   = req && ($urandom_range(0, 9) < 6);
      rdy   = ((cyc / 300) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      redir = ($urandom_range(0, 39) == 0);
      rpc   = $urandom;
      if (v && rdy && !redir) begin
        n_checks++; if (INST_PC !== exp_pop || INST_DATA !== memf(exp_pop)) begin
          n_errors++; $display("FAIL rnd_pop @%0d: got pc=%h data=%h expected pc=%h data=%h", cyc, INST_PC, INST_DATA,
                               exp_pop, memf(exp_pop)); end
        exp_pop = exp_pop + 32'd4;
        occ--;
      end
      if (redir) begin
        occ = 0;
        exp_fetch = rpc & 32'hFFFF_FFFC;
        exp_pop = exp_fetch;
        tainted = req && !ack;
      end else if (ack) begin
        if (tainted) tainted = 0;
        else begin
          n_checks++; if (addr !== exp_fetch) begin
            n_errors++; $display("FAIL rnd_addr @%0d: got %h expected %h", cyc, addr, exp_fetch); end
          exp_fetch = exp_fetch + 32'd4;
          occ++;
        end
      end
      prev_req = req; prev_ack = ack; prev_addr = addr;
      tick(ack, rdy, redir, rpc);
    end
  endtask

  initial begin
    RST = 1'b1; MEM_ACK = 0; INST_READY = 0; REDIRECT = 0; REDIRECT_PC = 0; MEM_RDATA = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_redirect_ack();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
